// File: rtl/ultrasonic_pkg.sv
// Shared types and default timing constants for the ultrasonic ranging blocks.
package ultrasonic_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2,
    HOLD      = 2'd3
  } state_e;

  // 58 us per cm of round trip at 50 MHz; 30 ms echo-start window.
  localparam int unsigned CYCLES_PER_CM_DEF = 2900;
  localparam int unsigned MAX_CM_DEF        = 400;
  localparam int unsigned WAIT_MAX_DEF      = 1_500_000;

  localparam int unsigned DIST_W = 9;

endpackage

// File: rtl/echo_distance_meter_if.sv
// Signal bundle for one echo_distance_meter: trigger/echo toward the meter, result back.
interface echo_distance_meter_if;
  import ultrasonic_pkg::*;

  logic              arm;
  logic              echo;
  logic              busy;
  logic [DIST_W-1:0] dist_cm;
  logic              dist_valid;
  logic              range_err;

  modport master (output arm, echo, input busy, dist_cm, dist_valid, range_err);
  modport slave  (input arm, echo, output busy, dist_cm, dist_valid, range_err);

endinterface

// File: rtl/echo_edge_detect.sv
// Echo synchronizer with rise/fall strobes on the conditioned level.
// Define ECHO_DEGLITCH_EN to require DEGLITCH_CYCLES equal samples before a level change.
module echo_edge_detect
`ifdef ECHO_DEGLITCH_EN
#(
  parameter int unsigned DEGLITCH_CYCLES = 8
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic echo,
  output logic echo_s,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic level;

  always_comb begin
    sync1_d = echo;
    sync2_d = sync1_q;
    prev_d  = level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

`ifdef ECHO_DEGLITCH_EN
  localparam int unsigned DG_W = $clog2(DEGLITCH_CYCLES + 1);

  logic            filt_q, filt_d;
  logic [DG_W-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive samples disagreeing with the accepted level.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == DG_W'(DEGLITCH_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign echo_s = level;
  assign rise   = level & ~prev_q;
  assign fall   = ~level & prev_q;

endmodule

// File: rtl/echo_distance_meter.sv
// Ultrasonic echo pulse-width to centimetre converter with timeout and saturation.
// ECHO_DEGLITCH_EN enables the echo deglitch filter inside echo_edge_detect.
module echo_distance_meter
  import ultrasonic_pkg::*;
#(
  parameter int unsigned CYCLES_PER_CM   = CYCLES_PER_CM_DEF,
  parameter int unsigned MAX_CM          = MAX_CM_DEF,
  parameter int unsigned WAIT_MAX        = WAIT_MAX_DEF,
  parameter int unsigned DEGLITCH_CYCLES = 8
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              echo,
  output logic              busy,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              range_err
);

  localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);
  localparam int unsigned PRE_W  = $clog2(CYCLES_PER_CM);

  if (CYCLES_PER_CM < 2 || MAX_CM == 0 || MAX_CM >= (1 << DIST_W) ||
      WAIT_MAX == 0 || DEGLITCH_CYCLES == 0) begin : g_bad_params
    $error("echo_distance_meter: unsupported parameter set");
  end

  logic echo_s, echo_rise, echo_fall;

`ifdef ECHO_DEGLITCH_EN
  echo_edge_detect #(.DEGLITCH_CYCLES(DEGLITCH_CYCLES)) u_edge (
    .clk(clk), .rst_n(rst_n), .echo(echo),
    .echo_s(echo_s), .rise(echo_rise), .fall(echo_fall)
  );
`else
  echo_edge_detect u_edge (
    .clk(clk), .rst_n(rst_n), .echo(echo),
    .echo_s(echo_s), .rise(echo_rise), .fall(echo_fall)
  );
`endif

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    pre_d   = pre_q;
    cm_d    = cm_q;
    dist_d  = dist_q;
    valid_d = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = WAIT_RISE;
          wait_d  = '0;
        end
      end
      WAIT_RISE: begin
        // The rise cycle itself is already one high cycle, so the prescaler starts at 1.
        if (echo_rise) begin
          state_d = MEASURE;
          pre_d   = PRE_W'(1);
          cm_d    = '0;
        end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
          state_d = IDLE;
          valid_d = 1'b1;
          dist_d  = DIST_W'(MAX_CM);
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      MEASURE: begin
        if (echo_fall) begin
          state_d = IDLE;
          valid_d = 1'b1;
          dist_d  = cm_q;
          err_d   = 1'b0;
        end else if (pre_q == PRE_W'(CYCLES_PER_CM - 1)) begin
          pre_d = '0;
          cm_d  = cm_q + 1'b1;
          if (cm_d == DIST_W'(MAX_CM)) begin
            state_d = HOLD;
            valid_d = 1'b1;
            dist_d  = DIST_W'(MAX_CM);
            err_d   = 1'b1;
          end
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      HOLD: begin
        if (!echo_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= '0;
      pre_q   <= '0;
      cm_q    <= '0;
      dist_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      pre_q   <= pre_d;
      cm_q    <= cm_d;
      dist_q  <= dist_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign dist_cm    = dist_q;
  assign dist_valid = valid_q;
  assign range_err  = err_q;

endmodule

// File: doc/echo_distance_meter.md
ECHO_DISTANCE_METER -- requirements
Module: echo_distance_meter

Interface
REQ-001 SHALL have parameter CYCLES_PER_CM, default 2900, meaning clk cycles of echo-high per centimetre (58 us at 50 MHz).
REQ-002 SHALL have parameter MAX_CM, default 400, meaning saturation distance and out-of-range limit.
REQ-003 SHALL have parameter WAIT_MAX, default 1_500_000, meaning cycles allowed from arm to echo rise (30 ms).
REQ-004 SHALL have parameter DEGLITCH_CYCLES, default 8, meaning stable cycles required by the deglitch filter.
REQ-005 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port arm, input, 1, meaning a one-cycle pulse from the trigger stage marking the end of the 10 us trigger.
REQ-008 SHALL have port echo, input, 1, meaning the raw asynchronous sensor echo pin.
REQ-009 SHALL have port busy, output, 1, meaning high whenever the FSM is not IDLE.
REQ-010 SHALL have port dist_cm, output, 9, meaning the last measured distance in cm.
REQ-011 SHALL have port dist_valid, output, 1, meaning a one-cycle pulse when dist_cm updates.
REQ-012 SHALL have port range_err, output, 1, meaning the last measurement saturated or timed out; valid with dist_valid.

Function
REQ-013 SHALL pass echo through a 2-flop synchronizer (echo_s); all edge detection SHALL use echo_s.
REQ-014 SHALL implement states IDLE, WAIT_RISE, MEASURE, HOLD.
REQ-015 SHALL move IDLE->WAIT_RISE on arm; arm in any other state SHALL be ignored.
REQ-016 SHALL move WAIT_RISE->MEASURE on an echo_s rising edge; echo_s already high on entry SHALL NOT count as a rise.
REQ-017 SHALL, in WAIT_RISE, after WAIT_MAX cycles without a rise, pulse dist_valid with range_err=1 and dist_cm=MAX_CM, then return to IDLE.
REQ-018 SHALL, in MEASURE, run a prescaler 0..CYCLES_PER_CM-1 that increments a cm counter on wrap; result = floor(high cycles / CYCLES_PER_CM), no divider.
REQ-019 SHALL, on an echo_s falling edge detected in cycle N, drive dist_valid high in cycle N+1 with dist_cm = cm counter and range_err=0, and return to IDLE.
REQ-020 SHALL, when the cm counter reaches MAX_CM, pulse dist_valid with dist_cm=MAX_CM and range_err=1, then enter HOLD.
REQ-021 SHALL leave HOLD for IDLE only when echo_s is low.
REQ-022 SHALL hold dist_cm and range_err between dist_valid pulses.
REQ-023 SHALL size internal counters from the parameters with no overflow at any default.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state=IDLE, busy=0, dist_cm=0, dist_valid=0, range_err=0, and clear all counters and synchronizer flops.
REQ-025 SHALL abandon a measurement in progress on reset mid-operation without emitting dist_valid.

Configuration
REQ-026 SHALL, with ECHO_DEGLITCH_EN defined, accept a level change of echo_s only after DEGLITCH_CYCLES consecutive equal samples, adding exactly DEGLITCH_CYCLES cycles of latency to both edges.
REQ-027 SHALL, without ECHO_DEGLITCH_EN, use echo_s directly with no added latency.

Structure
REQ-028 SHALL place the state enum and the default values of CYCLES_PER_CM, MAX_CM and WAIT_MAX in shared package ultrasonic_pkg.
REQ-029 SHALL implement the synchronizer, optional deglitch and rise/fall strobes in sub-module echo_edge_detect.

Verification
REQ-030 SHALL verify: arm, echo high 29000 cycles -> dist_valid once, dist_cm=10, range_err=0.
REQ-031 SHALL verify: arm, echo high 2899 cycles -> dist_cm=0; echo high 2900 cycles -> dist_cm=1.
REQ-032 SHALL verify: arm, echo never rises -> dist_valid after WAIT_MAX cycles, range_err=1, dist_cm=400.
REQ-033 SHALL verify: echo high 1_200_000 cycles -> dist_valid at 400 cm with range_err=1, busy until echo low, no second pulse.
REQ-034 SHALL verify: rst_n low mid-MEASURE -> all outputs 0 immediately, no dist_valid; a second arm while busy -> no effect.
REQ-035 SHALL verify, with ECHO_DEGLITCH_EN: a 5-cycle echo glitch -> no transition; a 29000-cycle pulse -> dist_cm=10.
